// File: rtl/stopwatch_display.sv
// Multiplexed MM:SS display for the stopwatch.
// The minutes and seconds inputs are binary values from 0 to 59. They are
// converted to BCD and scanned onto four active-low seven-segment digits.
// While adjust mode is active, the selected field blinks.
// A shadow copy of the time is taken once per full scan. This stops a
// single scan from mixing the old and new values of MM:SS.
module stopwatch_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [RW-1:0] r_refresh_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [5:0]    r_min_sh;
    logic [5:0]    r_sec_sh;
    logic          r_prime;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_refresh_wrap;
    logic          w_capture;
    logic          w_blank;
    logic [6:0]    w_digit_seg [4];
    logic [6:0]    w_seg_next;
    logic [3:0]    w_an_next;

    // Binary 0-59 to {tens, ones} by successive compare/subtract steps.
    function automatic logic [7:0] f_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        if (rem >= 6'd40) begin rem = rem - 6'd40; tens = tens + 4'd4; end
        if (rem >= 6'd20) begin rem = rem - 6'd20; tens = tens + 4'd2; end
        if (rem >= 6'd10) begin rem = rem - 6'd10; tens = tens + 4'd1; end
        return {tens, rem[3:0]};
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign w_refresh_wrap = (r_refresh_cnt == RW'(REFRESH_DIV - 1));
    // Capture the inputs on the first edge after reset, and again when the scan wraps from 3 to 0.
    assign w_capture      = r_prime | (w_refresh_wrap & (r_idx == 2'd3));
    // Slots 0 and 1 hold seconds (sel=1); slots 2 and 3 hold minutes (sel=0).
    assign w_blank        = adj & r_phase & (sel == ~r_idx[1]);

    // Build the segment pattern of every digit slot from the shadow time.
    // A shadow value of 60-63 is out of range, so both digits of that field show a dash.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [5:0] w_field;
            logic [7:0] w_bcd;
            assign w_field = (gi < 2) ? r_sec_sh : r_min_sh;
            assign w_bcd   = f_bcd(w_field);
            assign w_digit_seg[gi] = (w_field >= 6'd60) ? SEG_DASH
                                   : f_seg((gi % 2 == 1) ? w_bcd[7:4] : w_bcd[3:0]);
        end
    endgenerate

    // Next anode and segment values. The display stays blank until the first capture and whenever the slot is blinked off.
    always_comb begin
        w_an_next  = 4'b1111;
        w_seg_next = SEG_BLANK;
        if (!r_prime && !w_blank) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = w_digit_seg[r_idx];
        end
    end

    // Scan timing: the refresh prescaler, the digit index and the prime flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh_cnt <= '0;
            r_idx         <= 2'd0;
            r_prime       <= 1'b1;
        end else begin
            r_prime <= 1'b0;
            if (w_refresh_wrap) begin
                r_refresh_cnt <= '0;
                r_idx         <= r_idx + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + RW'(1);
            end
        end
    end

    // Shadow copy of the time. It changes only at the capture points.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_min_sh <= 6'd0;
            r_sec_sh <= 6'd0;
        end else if (w_capture) begin
            r_min_sh <= minutes;
            r_sec_sh <= seconds;
        end
    end

    // Blink timebase. It is held at phase 0 outside adjust mode, so each adjust session starts with the field visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!adj) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Registered pin drivers. This gives no combinational path from any input to the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display, run with REFRESH_DIV=4 and BLINK_DIV=16.
// The reference model treats the display as a pure function of time:
//   - the edge count since reset release gives the scan slot;
//   - the length of the current adj=1 run gives the blink phase;
//   - the shadow time is captured at edge 1 and at every 16th edge.
module tb_stopwatch_display;

    localparam int RD = 4;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] minutes = 6'd0;
    logic [5:0] seconds = 6'd0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;

    stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk     (clk),
        .rst     (rst),
        .minutes (minutes),
        .seconds (seconds),
        .adj     (adj),
        .sel     (sel),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_k;      // edges seen since reset release
    int m_run;    // consecutive edges that sampled adj=1
    int m_min;
    int m_sec;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;

    typedef struct {
        logic [5:0]  mn;
        logic [5:0]  sc;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vt[5];

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] s_req, input logic [3:0] a_req);
        total++;
        if (seg !== s_req || an !== a_req) begin
            bad++;
            $display("FAIL %s t=%0t: seg=%b an=%b, required seg=%b an=%b",
                     name, $time, seg, an, s_req, a_req);
        end
    endtask

    // Predict the pins after the edge that is happening now, then advance the model.
    task automatic model_eval();
        int idx;
        int field;
        int ph;
        bit sec_slot;
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
        if (m_k > 0) begin
            idx      = (m_k / RD) % 4;
            ph       = (m_run / BD) % 2;
            sec_slot = (idx < 2);
            field    = sec_slot ? m_sec : m_min;
            if (!(adj && ph == 1 && (sel == sec_slot))) begin
                exp_an = ~(4'b0001 << idx);
                if (field >= 60)
                    exp_seg = 7'b0111111;
                else
                    exp_seg = code((idx % 2 == 0) ? field % 10 : field / 10);
            end
        end
        if (m_k == 0 || (m_k % (RD * 4)) == RD * 4 - 1) begin
            m_min = int'(minutes);
            m_sec = int'(seconds);
        end
        m_run = adj ? m_run + 1 : 0;
        m_k++;
    endtask

    task automatic step();
        @(posedge clk);
        model_eval();
        #1;
        check("model", exp_seg, exp_an);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset away from a clock edge, check that the pins blank at once, then release.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("reset_async", 7'b1111111, 4'b1111);
        @(negedge clk);
        rst   = 1'b1;
        m_k   = 0;
        m_run = 0;
        m_min = 0;
        m_sec = 0;
    endtask

    initial begin
        vt[0] = '{mn: 6'd12, sc: 6'd34, segs: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vt[1] = '{mn: 6'd0,  sc: 6'd59, segs: {7'b1000000, 7'b1000000, 7'b0010010, 7'b0010000}};
        vt[2] = '{mn: 6'd0,  sc: 6'd62, segs: {7'b1000000, 7'b1000000, 7'b0111111, 7'b0111111}};
        vt[3] = '{mn: 6'd63, sc: 6'd7,  segs: {7'b0111111, 7'b0111111, 7'b1000000, 7'b1111000}};
        vt[4] = '{mn: 6'd48, sc: 6'd60, segs: {7'b0011001, 7'b0000000, 7'b0111111, 7'b0111111}};

        #2;
        do_reset();

        // Table: show each time value and check every digit slot.
        for (int v = 0; v < 5; v++) begin
            minutes = vt[v].mn;
            seconds = vt[v].sc;
            adj     = 1'b0;
            do_reset();
            step();
            check("prime_blank", 7'b1111111, 4'b1111);
            for (int d = 0; d < 4; d++) begin
                while (m_k < 4 * d + 2) step();
                check("table_digit", vt[v].segs[7*d +: 7], ~(4'b0001 << d));
            end
        end

        // A seconds change in mid-scan is held off until the next 3->0 wrap.
        minutes = 6'd12;
        seconds = 6'd34;
        do_reset();
        while (m_k < 2) step();
        check("first_anode", 7'b0011001, 4'b1110);
        while (m_k < 6) step();
        seconds = 6'd35;
        while (m_k < 13) step();
        check("min_tens_intact", 7'b1111001, 4'b0111);
        while (m_k < 17) step();
        check("sec_update", 7'b0010010, 4'b1110);

        // Blink: seconds blank in phase 1, then sel moves the blank to minutes, then adj drops.
        adj = 1'b1;
        sel = 1'b1;
        steps(16);
        for (int i = 0; i < 8; i++) begin
            step();
            if (((m_k - 1) / RD) % 4 < 2) check("blink_sec_blank", 7'b1111111, 4'b1111);
        end
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (((m_k - 1) / RD) % 4 >= 2) check("blink_min_blank", 7'b1111111, 4'b1111);
        end
        steps(40);
        adj = 1'b0;
        step();
        total++;
        if (an === 4'b1111) begin
            bad++;
            $display("FAIL adj_drop_visible: an=%b, required one anode low", an);
        end

        // Random traffic checked against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 4) == 0) minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) seconds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 59) == 0) adj = ~adj;
            if ($urandom_range(0, 29) == 0) sel = ~sel;
            if ($urandom_range(0, 699) == 0) do_reset();
            step();
        end

        // Reset in mid-scan, then check that the scan restarts at slot 0.
        adj     = 1'b0;
        minutes = 6'd7;
        seconds = 6'd21;
        steps(9);
        do_reset();
        steps(2);
        check("restart_idx0", 7'b1111001, 4'b1110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
